// File: rtl/cv32e40p_instr_obi_arbiter.sv
// cv32e40p_instr_obi_arbiter
// Two-requester OBI instruction-fetch arbiter onto one memory port.
// m0 = core prefetch, m1 = debug/aux fetch. Responses return in order and
// are routed back through an ID FIFO that is MAX_OUTSTANDING entries deep.
// Optional feature: define CV32E40P_INSTR_ARB_RR_EN for round-robin
// arbitration. Without it, m0 always has priority over m1.
// Grant, rvalid and request paths are combinational because OBI needs
// same-cycle handshakes. protocol_err_o is registered, so it pulses on the
// cycle after the unexpected rvalid.
module cv32e40p_instr_obi_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o,
    output logic        protocol_err_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_OUTSTANDING - 1);

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          r_fifo_id [MAX_OUTSTANDING];
    logic          r_locked;
    logic          r_lock_id;
    logic          r_protocol_err;
`ifdef CV32E40P_INSTR_ARB_RR_EN
    logic          r_last;
`endif

    logic          w_owner;
    logic          w_owner_req;
    logic          w_empty;
    logic          w_pop;
    logic          w_room;
    logic          w_issue;
    logic          w_accept;
    logic          w_head;

    // Advance a FIFO pointer and wrap it at the configured depth.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Pick the owner. A locked owner is kept; otherwise arbitrate among the active requesters.
    always_comb begin
        w_owner = 1'b0;
        if (r_locked) begin
            w_owner = r_lock_id;
        end else if (m0_req_i && m1_req_i) begin
`ifdef CV32E40P_INSTR_ARB_RR_EN
            w_owner = ~r_last;
`else
            w_owner = 1'b0;
`endif
        end else if (m1_req_i) begin
            w_owner = 1'b1;
        end else begin
            w_owner = 1'b0;
        end
    end

    assign w_owner_req = w_owner ? m1_req_i : m0_req_i;
    assign w_empty     = (r_count == {CW{1'b0}});
    assign w_pop       = instr_rvalid_i & ~w_empty & rst_n;
    // Issue is allowed at full capacity when a response frees a slot in the same cycle.
    assign w_room      = (r_count != COUNT_MAX) | w_pop;
    assign w_issue     = rst_n & w_owner_req & w_room;
    assign w_accept    = w_issue & instr_gnt_i;
    assign w_head      = r_fifo_id[r_rptr];

    assign instr_req_o    = w_issue;
    assign instr_addr_o   = w_owner ? m1_addr_i : m0_addr_i;
    assign m0_gnt_o       = w_accept & ~w_owner;
    assign m1_gnt_o       = w_accept & w_owner;
    assign m0_rvalid_o    = w_pop & ~w_head;
    assign m1_rvalid_o    = w_pop & w_head;
    assign m0_rdata_o     = instr_rdata_i;
    assign m1_rdata_o     = instr_rdata_i;
    assign m0_err_o       = instr_err_i;
    assign m1_err_o       = instr_err_i;
    assign busy_o         = (r_count != {CW{1'b0}}) | m0_req_i | m1_req_i;
    assign protocol_err_o = r_protocol_err;

    // Outstanding counter. Saturating guards keep it inside 0..MAX_OUTSTANDING.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CW{1'b0}};
        end else begin
            case ({w_accept, w_pop})
                2'b10:   if (r_count != COUNT_MAX) r_count <= r_count + CW'(1);
                2'b01:   if (r_count != {CW{1'b0}}) r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // In-order ID FIFO: push the owner on an accepted request, pop on a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= {PW{1'b0}};
            r_rptr <= {PW{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo_id[i] <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                r_fifo_id[r_wptr] <= w_owner;
                r_wptr            <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
        end
    end

    // Hold the owner while its request is issued but not yet granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked  <= 1'b0;
            r_lock_id <= 1'b0;
        end else if (w_issue && !instr_gnt_i) begin
            r_locked  <= 1'b1;
            r_lock_id <= w_owner;
        end else begin
            r_locked  <= 1'b0;
            r_lock_id <= r_lock_id;
        end
    end

    // Flag a response that arrives with nothing outstanding, as a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_protocol_err <= 1'b0;
        end else begin
            r_protocol_err <= instr_rvalid_i & w_empty;
        end
    end

`ifdef CV32E40P_INSTR_ARB_RR_EN
    // Remember the last granted requester. It resets to m1 so that m0 wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_owner;
        end else begin
            r_last <= r_last;
        end
    end
`endif

endmodule

// File: tb/tb_cv32e40p_instr_obi_arbiter.sv
// Directed testbench for cv32e40p_instr_obi_arbiter (MAX_OUTSTANDING = 2).
// Inputs change on the falling edge. Outputs are checked 1 ns later, away
// from the rising edge where the DUT state updates.
module tb_cv32e40p_instr_obi_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        m0_err_o, m1_err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] instr_rdata_i;
    logic        busy_o, protocol_err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cv32e40p_instr_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
        .busy_o(busy_o), .protocol_err_o(protocol_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Move to the next falling edge, where the bench applies new inputs.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Expected grant/rvalid sequence while both requesters ask for 4 cycles, then one drain cycle.
`ifdef CV32E40P_INSTR_ARB_RR_EN
    logic exp_g0 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_g1 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_r0 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_r1 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    logic exp_g0 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_g1 [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp_r0 [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic exp_r1 [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    initial begin
        rst_n = 1'b0; m0_req_i = 1'b1; m1_req_i = 1'b0;
        m0_addr_i = 32'h0; m1_addr_i = 32'h0;
        instr_gnt_i = 1'b1; instr_rvalid_i = 1'b0;
        instr_rdata_i = 32'h0; instr_err_i = 1'b0;

        // Reset state
        #1;
        check("rst_req", instr_req_o, 32'd0);
        check("rst_gnt0", m0_gnt_o, 32'd0);
        check("rst_busy", busy_o, 32'd1);
        check("rst_perr", protocol_err_o, 32'd0);
        check("rst_count", dut.r_count, 32'd0);
        next_cycle(); next_cycle();
        m0_req_i = 1'b0; instr_gnt_i = 1'b0; rst_n = 1'b1;
        #1 check("idle_busy", busy_o, 32'd0);

        // m0 alone, granted the same cycle, response on the next cycle
        next_cycle();
        m0_req_i = 1'b1; m0_addr_i = 32'h0000_1000; instr_gnt_i = 1'b1;
        #1;
        check("t1_req", instr_req_o, 32'd1);
        check("t1_addr", instr_addr_o, 32'h0000_1000);
        check("t1_gnt0", m0_gnt_o, 32'd1);
        check("t1_gnt1", m1_gnt_o, 32'd0);
        check("t1_cnt0", dut.r_count, 32'd0);
        next_cycle();
        m0_req_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0000_0013;
        #1;
        check("t1_cnt1", dut.r_count, 32'd1);
        check("t1_rv0", m0_rvalid_o, 32'd1);
        check("t1_rv1", m1_rvalid_o, 32'd0);
        check("t1_rdata", m0_rdata_o, 32'h0000_0013);
        next_cycle();
        instr_rvalid_i = 1'b0;
        #1;
        check("t1_cnt2", dut.r_count, 32'd0);
        check("t1_perr", protocol_err_o, 32'd0);

        // Both requesting for 4 cycles with gnt high; rvalid from cycle 2 keeps slots free
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            m0_req_i = (c < 4); m1_req_i = (c < 4);
            m0_addr_i = 32'h0000_00A0; m1_addr_i = 32'h0000_00B0;
            instr_gnt_i = 1'b1; instr_rvalid_i = (c > 0);
            #1;
            check($sformatf("t2_gnt0_c%0d", c), m0_gnt_o, 32'(exp_g0[c]));
            check($sformatf("t2_gnt1_c%0d", c), m1_gnt_o, 32'(exp_g1[c]));
            check($sformatf("t2_rv0_c%0d", c), m0_rvalid_o, 32'(exp_r0[c]));
            check($sformatf("t2_rv1_c%0d", c), m1_rvalid_o, 32'(exp_r1[c]));
        end
        next_cycle();
        instr_rvalid_i = 1'b0; instr_gnt_i = 1'b0;
        #1 check("t2_cnt", dut.r_count, 32'd0);

        // m1 is locked while gnt stays low, even after m0 starts requesting
        m1_req_i = 1'b1; m1_addr_i = 32'h0000_2000;
        #1;
        check("t3_addr_c1", instr_addr_o, 32'h0000_2000);
        check("t3_gnt1_c1", m1_gnt_o, 32'd0);
        for (int c = 2; c < 4; c++) begin
            next_cycle();
            m0_req_i = 1'b1; m0_addr_i = 32'h0000_3000;
            #1;
            check($sformatf("t3_addr_c%0d", c), instr_addr_o, 32'h0000_2000);
            check($sformatf("t3_gnt0_c%0d", c), m0_gnt_o, 32'd0);
        end
        next_cycle();
        instr_gnt_i = 1'b1;
        #1;
        check("t3_addr_c4", instr_addr_o, 32'h0000_2000);
        check("t3_gnt1_c4", m1_gnt_o, 32'd1);
        check("t3_gnt0_c4", m0_gnt_o, 32'd0);
        next_cycle();
        m1_req_i = 1'b0;
        #1;
        check("t3_addr_c5", instr_addr_o, 32'h0000_3000);
        check("t3_gnt0_c5", m0_gnt_o, 32'd1);

        // Full at two outstanding: no issue without rvalid; rvalid plus request issues
        next_cycle();
        #1;
        check("t4_cnt_full", dut.r_count, 32'd2);
        check("t4_req_blk", instr_req_o, 32'd0);
        check("t4_gnt_blk", m0_gnt_o, 32'd0);
        check("t4_busy", busy_o, 32'd1);
        next_cycle();
        instr_rvalid_i = 1'b1;
        #1;
        check("t4_req_ok", instr_req_o, 32'd1);
        check("t4_gnt_ok", m0_gnt_o, 32'd1);
        check("t4_rv1", m1_rvalid_o, 32'd1);
        check("t4_rv0", m0_rvalid_o, 32'd0);
        next_cycle();
        m0_req_i = 1'b0; instr_rvalid_i = 1'b0; instr_gnt_i = 1'b0;
        #1 check("t4_cnt_stay", dut.r_count, 32'd2);

        // Reset with two outstanding clears the count and blocks requests immediately
        m0_req_i = 1'b1; rst_n = 1'b0;
        #1;
        check("t5_cnt", dut.r_count, 32'd0);
        check("t5_req", instr_req_o, 32'd0);
        check("t5_busy", busy_o, 32'd1);
        next_cycle();
        m0_req_i = 1'b0; rst_n = 1'b1;

        // rvalid with nothing outstanding after reset: no routing, one-cycle error pulse
        next_cycle();
        instr_rvalid_i = 1'b1;
        #1;
        check("t6_rv0", m0_rvalid_o, 32'd0);
        check("t6_rv1", m1_rvalid_o, 32'd0);
        next_cycle();
        instr_rvalid_i = 1'b0;
        #1;
        check("t6_perr_hi", protocol_err_o, 32'd1);
        check("t6_cnt", dut.r_count, 32'd0);
        next_cycle();
        #1 check("t6_perr_lo", protocol_err_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
